// File: rtl/ddr_user_pkg.sv
// Shared widths, address field positions and FSM encoding for the DDR user-port stand-in.
package ddr_user_pkg;

  localparam int ROW_BITS_DEF = 13;
  localparam int COL_BITS_DEF = 10;
  localparam int BA_BITS_DEF  = 3;
  localparam int DQ_BITS_DEF  = 16;
  localparam int BL_MAX_DEF   = 8;

  localparam int ADDR_W = ROW_BITS_DEF + COL_BITS_DEF + BA_BITS_DEF;
  localparam int DATA_W = BL_MAX_DEF * DQ_BITS_DEF;

  // address = {bank,row,col}
  localparam int COL_LSB = 0;
  localparam int ROW_LSB = COL_BITS_DEF;
  localparam int BA_LSB  = COL_BITS_DEF + ROW_BITS_DEF;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_WR_WAIT,
    S_RD_WAIT,
    S_ACK
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ddr_user_mem.sv
// Single-port synchronous RAM holding one full burst per word.
module ddr_user_mem #(
  parameter int DATA_W = 128,
  parameter int AW     = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/ddr_user_port_responder.sv
// DDR3 user-port responder: answers read/write requests from an on-chip array
// with programmable init, write and read latencies.
module ddr_user_port_responder
  import ddr_user_pkg::*;
#(
  parameter int ROW_BITS    = 13,
  parameter int COL_BITS    = 10,
  parameter int BA_BITS     = 3,
  parameter int DQ_BITS     = 16,
  parameter int BL_MAX      = 8,
  parameter int MEM_AW      = 6,
  parameter int INIT_CYCLES = 200,
  parameter int WR_LATENCY  = 12,
  parameter int RD_LATENCY  = 20
) (
  input  logic                                i_clk,
  input  logic                                rst_i,
  input  logic                                read,
  input  logic                                write,
  input  logic [ROW_BITS+COL_BITS+BA_BITS-1:0] address,
  output logic [BL_MAX*DQ_BITS-1:0]           read_data,
  input  logic [BL_MAX*DQ_BITS-1:0]           write_data,
  output logic                                ack,
  output logic                                busy
);

  localparam int DW      = BL_MAX * DQ_BITS;
  localparam int COL_LOW = $clog2(BL_MAX);
  localparam int CNT_MAX = max3(INIT_CYCLES, WR_LATENCY, RD_LATENCY);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_CYCLES - 1);
  // Wait states run until the counter reaches the latency, so ack lands
  // LAT+1 edges after the accepting edge.
  localparam logic [CNT_W-1:0] WR_LAST   = CNT_W'(WR_LATENCY);
  localparam logic [CNT_W-1:0] RD_LAST   = CNT_W'(RD_LATENCY);
  localparam logic [CNT_W-1:0] RD_ISSUE  = CNT_W'(RD_LATENCY - 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_inc;
  logic [MEM_AW-1:0]  idx_q;
  logic [DW-1:0]      wdata_q;
  logic [DW-1:0]      mem_rdata;
  logic               mem_we;
  logic               mem_re;
  logic               accept;
  logic               unused_addr;

  assign unused_addr = ^address;
  assign cnt_inc     = (cnt == CNT_W'(CNT_MAX)) ? cnt : cnt + CNT_W'(1);
  assign accept      = (state == S_IDLE) && (write || read);

  // Commit is suppressed under reset so an abandoned write never lands.
  assign mem_we = !rst_i && (state == S_WR_WAIT) && (cnt == WR_LAST);
  assign mem_re = (state == S_RD_WAIT) && (cnt == RD_ISSUE);

  always_ff @(posedge i_clk) begin
    if (accept) begin
      idx_q   <= address[COL_LOW +: MEM_AW];
      wdata_q <= write_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (rst_i) begin
      state     <= S_INIT;
      cnt       <= '0;
      ack       <= 1'b0;
      busy      <= 1'b1;
      read_data <= '0;
    end else begin
      ack <= 1'b0;
      case (state)
        S_INIT: begin
          if (cnt == INIT_LAST) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        S_IDLE: begin
          cnt <= '0;
          if (write) begin
            state <= S_WR_WAIT;
            busy  <= 1'b1;
          end else if (read) begin
            state <= S_RD_WAIT;
            busy  <= 1'b1;
          end
        end
        S_WR_WAIT: begin
          if (cnt == WR_LAST) begin
            state <= S_ACK;
            ack   <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        S_RD_WAIT: begin
          if (cnt == RD_LAST) begin
            state     <= S_ACK;
            ack       <= 1'b1;
            read_data <= mem_rdata;
            cnt       <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        S_ACK: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_INIT;
          busy  <= 1'b1;
          cnt   <= '0;
        end
      endcase
    end
  end

  ddr_user_mem #(
    .DATA_W(DW),
    .AW    (MEM_AW)
  ) u_mem (
    .clk  (i_clk),
    .we   (mem_we),
    .re   (mem_re),
    .addr (idx_q),
    .wdata(wdata_q),
    .rdata(mem_rdata)
  );

endmodule

// File: tb/tb_ddr_user_port_responder.sv
// Directed bench for ddr_user_port_responder with short latencies.
module tb_ddr_user_port_responder;

  localparam int INIT_C = 10;
  localparam int WR_L   = 3;
  localparam int RD_L   = 5;

  localparam logic [25:0] A1  = {3'd3, 13'h17e6, 10'h188};
  localparam logic [25:0] A1B = {3'd3, 13'h17e6, 10'h18f};
  localparam logic [25:0] A2  = {3'd1, 13'h0abc, 10'h050};
  localparam logic [25:0] A3  = {3'd5, 13'h1234, 10'h028};
  localparam logic [25:0] A4  = {3'd0, 13'h0001, 10'h070};
  localparam logic [25:0] A5  = {3'd7, 13'h1fff, 10'h018};

  localparam logic [127:0] D1 = 128'h9215_3524_4089_5e81_0484_d609_31f0_5663;
  localparam logic [127:0] D2 = 128'hdead_beef_0123_4567_89ab_cdef_f00d_cafe;
  localparam logic [127:0] D3 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [127:0] D4 = 128'ha5a5_5a5a_0f0f_f0f0_c3c3_3c3c_9696_6969;
  localparam logic [127:0] D5 = 128'h0000_0001_0000_0002_0000_0003_0000_0004;
  localparam logic [127:0] D6 = 128'hfedc_ba98_7654_3210_0011_2233_4455_6677;

  logic         clk = 1'b0;
  logic         rst_i = 1'b1;
  logic         read = 1'b0;
  logic         write = 1'b0;
  logic [25:0]  address = '0;
  logic [127:0] write_data = '0;
  logic [127:0] read_data;
  logic         ack;
  logic         busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ddr_user_port_responder #(
    .ROW_BITS(13), .COL_BITS(10), .BA_BITS(3), .DQ_BITS(16), .BL_MAX(8),
    .MEM_AW(4), .INIT_CYCLES(INIT_C), .WR_LATENCY(WR_L), .RD_LATENCY(RD_L)
  ) dut (
    .i_clk(clk), .rst_i(rst_i), .read(read), .write(write), .address(address),
    .read_data(read_data), .write_data(write_data), .ack(ack), .busy(busy)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one request from IDLE, holds it until ack, returns edges from accept to ack.
  task automatic do_op(input bit wr, input bit rd, input logic [25:0] a,
                       input logic [127:0] d, input bit scramble,
                       output int lat, output logic busy_after);
    write = wr; read = rd; address = a; write_data = d;
    tick();
    busy_after = busy;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      if (scramble) begin
        address    = 26'($urandom());
        write_data = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
      tick();
      if (ack) begin
        lat = k;
        break;
      end
    end
    write = 1'b0; read = 1'b0;
    tick();
  endtask

  // Counts edges until busy drops after reset release; flags any ack seen.
  task automatic init_len(output int n, output bit saw_ack);
    n = -1; saw_ack = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (ack) saw_ack = 1'b1;
      if (!busy) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int n; bit sa;
    rst_i = 1'b1;
    repeat (3) tick();
    rst_i = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b expected 1", busy); end
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0", ack); end
    checks++; if (read_data !== 128'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", read_data); end
    init_len(n, sa);
    checks++; if (n != INIT_C) begin errors++; $display("FAIL init_len: got %0d expected %0d", n, INIT_C); end
    checks++; if (sa) begin errors++; $display("FAIL init_ack: got 1 expected 0"); end
  endtask

  task automatic test_write_read();
    int lat; logic b;
    do_op(1'b1, 1'b0, A1, D1, 1'b0, lat, b);
    checks++; if (lat != WR_L + 1) begin errors++; $display("FAIL wr_latency: got %0d expected %0d", lat, WR_L + 1); end
    checks++; if (b !== 1'b1) begin errors++; $display("FAIL wr_busy_after_accept: got %b expected 1", b); end
    do_op(1'b0, 1'b1, A1, '0, 1'b0, lat, b);
    checks++; if (lat != RD_L + 1) begin errors++; $display("FAIL rd_latency: got %0d expected %0d", lat, RD_L + 1); end
    checks++; if (read_data !== D1) begin errors++; $display("FAIL rd_data: got %h expected %h", read_data, D1); end
  endtask

  task automatic test_priority_alias();
    int lat; logic b;
    do_op(1'b1, 1'b1, A2, D2, 1'b0, lat, b);
    checks++; if (lat != WR_L + 1) begin errors++; $display("FAIL prio_latency: got %0d expected %0d", lat, WR_L + 1); end
    do_op(1'b0, 1'b1, A2, '0, 1'b0, lat, b);
    checks++; if (read_data !== D2) begin errors++; $display("FAIL prio_data: got %h expected %h", read_data, D2); end
    do_op(1'b1, 1'b0, A1, D3, 1'b0, lat, b);
    do_op(1'b0, 1'b1, A1B, '0, 1'b0, lat, b);
    checks++; if (read_data !== D3) begin errors++; $display("FAIL alias_data: got %h expected %h", read_data, D3); end
    checks++; if (lat != RD_L + 1) begin errors++; $display("FAIL alias_latency: got %0d expected %0d", lat, RD_L + 1); end
  endtask

  task automatic test_back_to_back();
    int acks = 0, gap = 0, bad_gap = 0, dbl = 0, spur = 0, lat;
    logic ack_prev = 1'b0, b;
    write = 1'b1; address = A3; write_data = D4;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (ack) begin
        if (ack_prev) dbl++;
        if (acks > 0 && gap != 1) bad_gap++;
        acks++;
        gap = 0;
        if (acks == 3) begin
          write = 1'b0;
          break;
        end
      end else if (!busy) begin
        gap++;
      end
      ack_prev = ack;
    end
    checks++; if (acks != 3) begin errors++; $display("FAIL held_acks: got %0d expected 3", acks); end
    checks++; if (bad_gap != 0) begin errors++; $display("FAIL held_idle_gap: got %0d bad gaps expected 0", bad_gap); end
    checks++; if (dbl != 0) begin errors++; $display("FAIL held_ack_width: got %0d long acks expected 0", dbl); end
    for (int k = 0; k < 8; k++) begin
      tick();
      if (ack) spur++;
    end
    checks++; if (spur != 0) begin errors++; $display("FAIL held_spurious: got %0d acks expected 0", spur); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL held_idle_busy: got %b expected 0", busy); end
    do_op(1'b0, 1'b1, A3, '0, 1'b0, lat, b);
    checks++; if (read_data !== D4) begin errors++; $display("FAIL held_data: got %h expected %h", read_data, D4); end
  endtask

  task automatic test_reset_mid_read();
    int lat, n; logic b; bit sa; bit seen = 1'b0;
    do_op(1'b1, 1'b0, A4, D5, 1'b0, lat, b);
    do_op(1'b0, 1'b1, A1, '0, 1'b0, lat, b);
    checks++; if (read_data !== D3) begin errors++; $display("FAIL mid_pre_data: got %h expected %h", read_data, D3); end
    read = 1'b1; address = A4;
    tick();
    read = 1'b0;
    tick();
    if (ack) seen = 1'b1;
    tick();
    if (ack) seen = 1'b1;
    checks++; if (read_data !== D3) begin errors++; $display("FAIL mid_wait_data: got %h expected %h", read_data, D3); end
    rst_i = 1'b1;
    tick();
    if (ack) seen = 1'b1;
    tick();
    if (ack) seen = 1'b1;
    rst_i = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_reset_busy: got %b expected 1", busy); end
    checks++; if (read_data !== 128'h0) begin errors++; $display("FAIL mid_reset_rdata: got %h expected 0", read_data); end
    init_len(n, sa);
    if (sa) seen = 1'b1;
    checks++; if (seen) begin errors++; $display("FAIL mid_no_ack: got ack expected none"); end
    checks++; if (n != INIT_C) begin errors++; $display("FAIL mid_init_len: got %0d expected %0d", n, INIT_C); end
    do_op(1'b0, 1'b1, A4, '0, 1'b0, lat, b);
    checks++; if (read_data !== D5) begin errors++; $display("FAIL mid_retained: got %h expected %h", read_data, D5); end
  endtask

  task automatic test_input_latch();
    int lat; logic b;
    do_op(1'b1, 1'b0, A5, D6, 1'b1, lat, b);
    checks++; if (lat != WR_L + 1) begin errors++; $display("FAIL latch_latency: got %0d expected %0d", lat, WR_L + 1); end
    do_op(1'b0, 1'b1, A5, '0, 1'b0, lat, b);
    checks++; if (read_data !== D6) begin errors++; $display("FAIL latch_data: got %h expected %h", read_data, D6); end
    do_op(1'b0, 1'b1, A1, '0, 1'b0, lat, b);
    checks++; if (read_data !== D3) begin errors++; $display("FAIL latch_other: got %h expected %h", read_data, D3); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_priority_alias();
    test_back_to_back();
    test_reset_mid_read();
    test_input_latch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
